// File: rtl/br_resolve_ctrl.sv
// Branch resolve controller: queues IF-stage predictions, checks them against the
// EX outcome, and on a mispredict squashes IF/ID and redirects fetch.
module br_resolve_ctrl #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             if_br_valid,
  input  logic             if_pred_taken,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_target,
  input  logic             ex_br_valid,
  input  logic             ex_taken,
  output logic             pred_wrong,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             q_full,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic             err_underflow,
  output logic             dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int EW = 2 * XLEN + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Handshake: an IF branch is accepted (push) only in a non-stalled IDLE cycle with
  // room in the queue (or a same-cycle pop); an EX resolve (pop) needs a non-stalled
  // IDLE cycle and a non-empty queue. Both are single-cycle qualifiers, no backpressure
  // beyond q_full.
  logic [EW-1:0]    mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             flush_q, flush_d;
  logic             rv_q, rv_d;
  logic [XLEN-1:0]  rpc_q, rpc_d;
  logic [CNT_W-1:0] cntb_q, cntb_d;
  logic [CNT_W-1:0] cntm_q, cntm_d;
  logic             err_q, err_d;

  logic             active;
  logic             full;
  logic             pop;
  logic             push;
  logic             mis;
  logic             underflow;
  logic [EW-1:0]    head;
  logic             head_taken;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  head_tgt;

  assign active     = !stall && (state_q == IDLE);
  assign full       = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign head_taken = head[EW-1];
  assign head_pc    = head[EW-2:XLEN];
  assign head_tgt   = head[XLEN-1:0];
  assign pop        = ex_br_valid && active && (count_q != '0);
  assign mis        = pop && (ex_taken != head_taken);
  assign push       = if_br_valid && active && !mis && (!full || pop);
  assign underflow  = ex_br_valid && active && (count_q == '0);

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    flush_d  = flush_q;
    rv_d     = rv_q;
    rpc_d    = rpc_q;
    cntb_d   = cntb_q;
    cntm_d   = cntm_q;
    err_d    = err_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (mis) begin
            // Every younger entry is on the wrong path, so the whole queue goes.
            state_d  = FLUSH;
            fcnt_d   = FW'(FLUSH_CYC - 1);
            flush_d  = 1'b1;
            rv_d     = 1'b1;
            rpc_d    = ex_taken ? head_tgt : head_pc + XLEN'(4);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
          end
        end
        FLUSH: begin
          rv_d = 1'b0;
          if (fcnt_q == '0) begin
            state_d = IDLE;
            flush_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q - FW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (pop && (cntb_q != CNT_MAX)) cntb_d = cntb_q + CNT_W'(1);
      if (mis && (cntm_q != CNT_MAX)) cntm_d = cntm_q + CNT_W'(1);
      if (underflow) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fcnt_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      flush_q  <= 1'b0;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
      cntb_q   <= '0;
      cntm_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flush_q  <= flush_d;
      rv_q     <= rv_d;
      rpc_q    <= rpc_d;
      cntb_q   <= cntb_d;
      cntm_q   <= cntm_d;
      err_q    <= err_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {if_pred_taken, if_pc, if_target};
  end

  assign pred_wrong     = mis;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign q_full         = full;
  assign cnt_branches   = cntb_q;
  assign cnt_mispred    = cntm_q;
  assign err_underflow  = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the branch bookkeeping.
module tb_br_resolve_ctrl;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             if_br_valid;
  logic             if_pred_taken;
  logic [XLEN-1:0]  if_pc;
  logic [XLEN-1:0]  if_target;
  logic             ex_br_valid;
  logic             ex_taken;
  logic             pred_wrong;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             q_full;
  logic [CNT_W-1:0] cnt_branches;
  logic [CNT_W-1:0] cnt_mispred;
  logic             err_underflow;
  logic             dbg_state_o;

  br_resolve_ctrl #(
    .XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_br_valid(if_br_valid), .if_pred_taken(if_pred_taken),
    .if_pc(if_pc), .if_target(if_target),
    .ex_br_valid(ex_br_valid), .ex_taken(ex_taken),
    .pred_wrong(pred_wrong), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .q_full(q_full), .cnt_branches(cnt_branches), .cnt_mispred(cnt_mispred),
    .err_underflow(err_underflow), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {pred_taken, pc, target} plus flush cycles remaining.
  logic [2*XLEN:0] exp_q[$];
  int              m_frem;
  logic            m_rv;
  logic [XLEN-1:0] m_rpc;
  int              m_cntb;
  int              m_cntm;
  logic            m_err;

  logic obs_pw;
  logic obs_flush;
  logic obs_rv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_frem = 0;
    m_rv   = 1'b0;
    m_rpc  = '0;
    m_cntb = 0;
    m_cntm = 0;
    m_err  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare just after, advance model past posedge.
  task automatic cycle(input logic rst, input logic st, input logic ibv, input logic ipt,
                       input logic [XLEN-1:0] ipc, input logic [XLEN-1:0] itgt,
                       input logic ebv, input logic etk);
    logic            idle;
    logic            res;
    logic            mis;
    logic            psh;
    int              sz;
    logic [2*XLEN:0] hd;
    rst_n = rst; stall = st; if_br_valid = ibv; if_pred_taken = ipt;
    if_pc = ipc; if_target = itgt; ex_br_valid = ebv; ex_taken = etk;
    #1;
    idle = (m_frem == 0);
    sz   = exp_q.size();
    res  = ebv && !st && idle && (sz > 0);
    mis  = 1'b0;
    hd   = '0;
    if (res) begin
      hd  = exp_q[0];
      mis = (etk != hd[2*XLEN]);
    end
    psh = ibv && !st && idle && !mis && ((sz < DEPTH) || res);

    obs_pw = pred_wrong; obs_flush = flush; obs_rv = redirect_valid;
    chk("pred_wrong", {63'd0, pred_wrong}, {63'd0, mis});
    chk("flush", {63'd0, flush}, {63'd0, m_frem > 0});
    chk("dbg_state", {63'd0, dbg_state_o}, {63'd0, m_frem > 0});
    chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
    chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, m_rpc});
    chk("q_full", {63'd0, q_full}, {63'd0, sz == DEPTH});
    chk("cnt_branches", {60'd0, cnt_branches}, 64'(m_cntb));
    chk("cnt_mispred", {60'd0, cnt_mispred}, 64'(m_cntm));
    chk("err_underflow", {63'd0, err_underflow}, {63'd0, m_err});

    if (!rst) begin
      model_reset();
    end else if (!st) begin
      if (!idle) begin
        m_frem--;
        m_rv = 1'b0;
      end else if (mis) begin
        m_rpc  = etk ? hd[XLEN-1:0] : hd[2*XLEN-1:XLEN] + 32'd4;
        exp_q.delete();
        m_frem = FLUSH_CYC;
        m_rv   = 1'b1;
        if (m_cntb < CNT_MAX) m_cntb++;
        if (m_cntm < CNT_MAX) m_cntm++;
      end else begin
        if (res) begin
          void'(exp_q.pop_front());
          if (m_cntb < CNT_MAX) m_cntb++;
        end
        if (psh) exp_q.push_back({ipt, ipc, itgt});
        if (ebv && (sz == 0)) m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Driver shorthands
  task automatic idle_cyc();
    cycle(1, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic push(input logic pred, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt);
    cycle(1, 0, 1, pred, pc, tgt, 0, 0);
  endtask

  task automatic resolve(input logic tk);
    cycle(1, 0, 0, 0, '0, '0, 1, tk);
  endtask

  initial begin
    int n_fl;
    int n_rv;
    int n_pw;
    rst_n = 0; stall = 0; if_br_valid = 0; if_pred_taken = 0;
    if_pc = '0; if_target = '0; ex_br_valid = 0; ex_taken = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_cnt_b", {60'd0, cnt_branches}, 64'd0);
    chk("rst_err", {63'd0, err_underflow}, 64'd0);

    // Correct prediction
    push(1, 32'h100, 32'h200);
    resolve(1);
    chk("t1_pw", {63'd0, obs_pw}, 64'd0);
    chk("t1_flush", {63'd0, flush}, 64'd0);
    chk("t1_cnt_b", {60'd0, cnt_branches}, 64'd1);

    // Mispredict, taken
    push(0, 32'h100, 32'h180);
    resolve(1);
    chk("t2_pw", {63'd0, obs_pw}, 64'd1);
    chk("t2_flush_c1", {63'd0, flush}, 64'd1);
    chk("t2_rv_c1", {63'd0, redirect_valid}, 64'd1);
    chk("t2_rpc", {32'd0, redirect_pc}, 64'h180);
    chk("t2_cnt_m", {60'd0, cnt_mispred}, 64'd1);
    idle_cyc();
    chk("t2_flush_c2", {63'd0, flush}, 64'd1);
    chk("t2_rv_c2", {63'd0, redirect_valid}, 64'd0);
    idle_cyc();
    chk("t2_flush_c3", {63'd0, flush}, 64'd0);

    // Mispredict, not taken, squashes younger entries
    push(1, 32'h40, 32'h80);
    push(0, 32'h50, 32'h90);
    push(1, 32'h60, 32'ha0);
    resolve(0);
    chk("t3_rpc", {32'd0, redirect_pc}, 64'h44);
    idle_cyc();
    idle_cyc();
    resolve(1);
    chk("t3_err", {63'd0, err_underflow}, 64'd1);
    chk("t3_cnt_b", {60'd0, cnt_branches}, 64'd3);
    chk("t3_cnt_m", {60'd0, cnt_mispred}, 64'd2);

    // Full queue
    for (int i = 0; i < DEPTH; i++) push(1, 32'h1000 + 32'(i * 16), 32'h2000);
    chk("t4_full", {63'd0, q_full}, 64'd1);
    cycle(1, 0, 1, 1, 32'h1100, 32'h2100, 1, 1);
    chk("t4_full_pp", {63'd0, q_full}, 64'd1);
    push(1, 32'h1200, 32'h2200);
    chk("t4_full_drop", {63'd0, q_full}, 64'd1);
    for (int i = 0; i < DEPTH; i++) resolve(1);
    chk("t4_empty", {63'd0, q_full}, 64'd0);

    // Stall during flush extends it
    push(0, 32'h300, 32'h400);
    resolve(1);
    n_fl = 0; n_rv = 0; n_pw = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 1, 32'h500, 32'h600, 1, 0);
      n_fl += int'(obs_flush); n_rv += int'(obs_rv); n_pw += int'(obs_pw);
    end
    for (int i = 0; i < 4; i++) begin
      idle_cyc();
      n_fl += int'(obs_flush); n_rv += int'(obs_rv);
    end
    chk("t5_flush_len", 64'(n_fl), 64'd5);
    chk("t5_rv_len", 64'(n_rv), 64'd4);
    chk("t5_pw_stall", 64'(n_pw), 64'd0);
    chk("t5_rpc", {32'd0, redirect_pc}, 64'h400);

    // Reset mid-flush
    push(1, 32'h700, 32'h800);
    resolve(0);
    cycle(0, 0, 0, 0, '0, '0, 0, 0);
    chk("t6_flush", {63'd0, flush}, 64'd0);
    chk("t6_rv", {63'd0, redirect_valid}, 64'd0);
    chk("t6_err", {63'd0, err_underflow}, 64'd0);

    // Counter saturation at 2^CNT_W-1
    for (int i = 0; i < 20; i++) begin
      push(1, 32'h900, 32'ha00);
      resolve(1);
    end
    chk("t7_sat", {60'd0, cnt_branches}, 64'd15);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [XLEN-1:0] pc;
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 499) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, 1'($urandom), pc, $urandom,
            $urandom_range(0, 9) < 4, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
